// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the switch debouncer bank.
// Timing defaults assume a 25 MHz system clock.
package debounce_pkg;

  localparam int DEB_10MS_25MHZ  = 250000;
  localparam int REP_500MS_25MHZ = 12500000;
  localparam int REP_100MS_25MHZ = 2500000;

  // Bits needed to hold 0..max_count; never returns zero.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, qualification counter, edge strobes
// and, with DEBOUNCE_REPEAT_EN defined, a held-button auto-repeat counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   WAIT_CYCLES   = DEB_10MS_25MHZ,
  parameter logic INIT_LEVEL    = 1'b0,
  parameter int   REPEAT_DELAY  = REP_500MS_25MHZ,
  parameter int   REPEAT_PERIOD = REP_100MS_25MHZ
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch,
  output logic o_switch,
  output logic o_rise,
  output logic o_fall,
  output logic o_repeat
);

  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;
  logic          commit;

  // New level has differed for WAIT_CYCLES consecutive edges, including this one.
  assign commit = (sync1 != o_switch) && (cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync0    <= INIT_LEVEL;
      sync1    <= INIT_LEVEL;
      cnt      <= '0;
      o_switch <= INIT_LEVEL;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
    end else begin
      sync0  <= i_switch;
      sync1  <= sync0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      if (sync1 == o_switch) begin
        cnt <= '0;
      end else if (commit) begin
        o_switch <= sync1;
        cnt      <= '0;
        o_rise   <= sync1;
        o_fall   <= ~sync1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] RLOAD_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RLOAD_PERIOD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt;

  // A falling commit clears the counter on the same edge, so no strobe follows o_fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rep_cnt  <= '0;
      o_repeat <= 1'b0;
    end else begin
      o_repeat <= 1'b0;
      if (commit) begin
        rep_cnt <= sync1 ? RLOAD_DELAY : '0;
      end else if (o_switch) begin
        if (rep_cnt == '0) begin
          o_repeat <= 1'b1;
          rep_cnt  <= RLOAD_PERIOD;
        end else begin
          rep_cnt <= rep_cnt - RW'(1);
        end
      end
    end
  end
`else
  // Repeat delays are always >= 1, so this folds to a constant 0.
  assign o_repeat = (REPEAT_DELAY == 0) && (REPEAT_PERIOD == 0);
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer; one independent debounce_channel per input bit.
// Auto-repeat strobes are built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   CHANNELS      = 4,
  parameter int   WAIT_CYCLES   = DEB_10MS_25MHZ,
  parameter logic INIT_LEVEL    = 1'b0,
  parameter int   REPEAT_DELAY  = REP_500MS_25MHZ,
  parameter int   REPEAT_PERIOD = REP_100MS_25MHZ
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_switch,
  output logic [CHANNELS-1:0] o_switch,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_repeat
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    debounce_channel #(
      .WAIT_CYCLES  (WAIT_CYCLES),
      .INIT_LEVEL   (INIT_LEVEL),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_switch(i_switch[n]),
      .o_switch(o_switch[n]),
      .o_rise  (o_rise[n]),
      .o_fall  (o_fall[n]),
      .o_repeat(o_repeat[n])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: a per-cycle behavioural model plus
// hand-computed literal checks for latency, bounce, glitch, reset and repeat.
module tb_debounce_bank;

  localparam int CH = 2;
  localparam int W  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef DEBOUNCE_REPEAT_EN
  localparam logic REP_ON = 1'b1;
`else
  localparam logic REP_ON = 1'b0;
`endif

  // clock / reset
  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [CH-1:0] i_switch = '0;
  logic [CH-1:0] o_switch, o_rise, o_fall, o_repeat;

  always #5 i_clk = ~i_clk;

  debounce_bank #(
    .CHANNELS     (CH),
    .WAIT_CYCLES  (W),
    .INIT_LEVEL   (1'b0),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_switch(i_switch),
    .o_switch(o_switch),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_repeat(o_repeat)
  );

  int errors = 0;
  int checks = 0;

  // Model: the level seen by the logic is the raw input two edges old; a channel
  // commits once its last W seen samples all differ from the committed level.
  logic [CH-1:0] in_q[$];
  logic [W-1:0]  hist[CH];
  logic [CH-1:0] m_level, m_rise, m_fall, m_rep, m_s1;
  int            edge_n;
  int            rise_edge[CH];

  task automatic model_reset();
    in_q.delete();
    in_q.push_back({CH{1'b0}});
    in_q.push_back({CH{1'b0}});
    for (int c = 0; c < CH; c++) begin
      hist[c]      = {W{1'b0}};
      rise_edge[c] = 0;
    end
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_rep   = '0;
    edge_n  = 0;
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      model_reset();
    end else begin
      m_s1 = in_q.pop_front();
      in_q.push_back(i_switch);
      edge_n++;
      m_rise = '0;
      m_fall = '0;
      m_rep  = '0;
      for (int c = 0; c < CH; c++) begin
        hist[c] = {hist[c][W-2:0], m_s1[c]};
        if (hist[c] == {W{~m_level[c]}}) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            m_rise[c]    = 1'b1;
            rise_edge[c] = edge_n;
          end else begin
            m_fall[c] = 1'b1;
          end
        end
`ifdef DEBOUNCE_REPEAT_EN
        else if (m_level[c] && (edge_n - rise_edge[c]) >= RD &&
                 ((edge_n - rise_edge[c] - RD) % RP) == 0) begin
          m_rep[c] = 1'b1;
        end
`endif
      end
    end
  end

  // scoreboard: per-cycle compare against the model
  always @(negedge i_clk) begin
    checks++;
    if ({o_switch, o_rise, o_fall, o_repeat} !== {m_level, m_rise, m_fall, m_rep}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got sw=%b r=%b f=%b rep=%b exp sw=%b r=%b f=%b rep=%b",
               $time, o_switch, o_rise, o_fall, o_repeat, m_level, m_rise, m_fall, m_rep);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
    end
  endtask

  initial begin
    model_reset();
    step(2);
    chk("reset_state", 8'({o_switch, o_rise, o_fall, o_repeat}), 8'h00);
    #2 i_rst_n = 1'b1;
    step(3);

    // clean press on ch0, held long enough to exercise auto-repeat
    i_switch[0] = 1'b1;
    step(5);
    chk("press_wait", 8'(o_switch[0]), 8'd0);
    step(1);
    chk("press_commit", 8'({o_switch[0], o_rise[0], o_fall[0]}), 8'b110);
    step(1);
    chk("press_rise_once", 8'(o_rise[0]), 8'd0);
    step(9);
    chk("repeat_first", 8'(o_repeat[0]), 8'(REP_ON));
    step(1);
    chk("repeat_gap", 8'(o_repeat[0]), 8'd0);
    step(2);
    chk("repeat_second", 8'(o_repeat[0]), 8'(REP_ON));
    step(3);
    chk("repeat_third", 8'(o_repeat[0]), 8'(REP_ON));
    step(15);
    // fall lands on rise+37, exactly where a repeat would otherwise be due
    i_switch[0] = 1'b0;
    step(6);
    chk("fall_no_repeat", 8'({o_switch[0], o_fall[0], o_repeat[0]}), 8'b010);
    step(8);

    // bounce 1,0,1 in 2-cycle segments, then hold
    i_switch[0] = 1'b1;
    step(2);
    i_switch[0] = 1'b0;
    step(2);
    i_switch[0] = 1'b1;
    step(5);
    chk("bounce_wait", 8'(o_switch[0]), 8'd0);
    step(1);
    chk("bounce_commit", 8'({o_switch[0], o_rise[0]}), 8'b11);
    i_switch[0] = 1'b0;
    step(8);

    // 3-cycle glitch on ch1
    i_switch[1] = 1'b1;
    step(3);
    i_switch[1] = 1'b0;
    step(8);
    chk("glitch_ignored", 8'(o_switch[1]), 8'd0);

    // simultaneous press and release
    i_switch = 2'b11;
    step(6);
    chk("simul_rise", 8'({o_rise, o_switch}), 8'b1111);
    step(1);
    chk("simul_rise_once", 8'(o_rise), 8'd0);
    i_switch = 2'b00;
    step(6);
    chk("simul_fall", 8'({o_fall, o_switch}), 8'b1100);
    step(1);
    chk("simul_fall_once", 8'(o_fall), 8'd0);
    step(2);

    // reset during ch0 qualification with ch1 already committed high
    i_switch[1] = 1'b1;
    step(8);
    i_switch[0] = 1'b1;
    step(4);
    chk("pre_reset", 8'(o_switch), 8'b10);
    #2 i_rst_n = 1'b0;
    #1 chk("reset_async", 8'({o_switch, o_rise, o_fall, o_repeat}), 8'h00);
    step(1);
    #2 i_rst_n = 1'b1;
    step(5);
    chk("post_reset_wait", 8'(o_switch), 8'b00);
    step(1);
    chk("post_reset_commit", 8'({o_switch, o_rise}), 8'b1111);
    i_switch = 2'b00;
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
